// File: rtl/ssm_io_sequencer.sv
// Host-side initiator for the fp16 SSM block: loads one operand frame into flat buses,
// fires a single start pulse, waits for done (with watchdog) and streams the result back out.
module ssm_io_sequencer #(
  parameter int unsigned B      = 1,
  parameter int unsigned H      = 4,
  parameter int unsigned P      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned TO_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic [B*H*DW-1:0]     dt_flat,
  output logic [B*H*DW-1:0]     dA_flat,
  output logic [B*N*DW-1:0]     Bmat_flat,
  output logic [B*N*DW-1:0]     C_flat,
  output logic [H*DW-1:0]       D_flat,
  output logic [B*H*P*DW-1:0]   x_flat,
  output logic [B*H*P*N*DW-1:0] h_prev_flat,
  output logic                  ssm_start,
  input  logic                  ssm_done,
  input  logic [B*H*P*DW-1:0]   y_flat_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam int unsigned NBH  = B * H;
  localparam int unsigned NBN  = B * N;
  localparam int unsigned NX   = B * H * P;
  localparam int unsigned NHP  = B * H * P * N;
  localparam int unsigned O_DT = 0;
  localparam int unsigned O_DA = O_DT + NBH;
  localparam int unsigned O_BM = O_DA + NBH;
  localparam int unsigned O_C  = O_BM + NBN;
  localparam int unsigned O_D  = O_C + NBN;
  localparam int unsigned O_X  = O_D + H;
  localparam int unsigned O_HP = O_X + NX;
  localparam int unsigned L    = O_HP + NHP;
  localparam int unsigned IW   = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned JW   = (NX > 1) ? $clog2(NX) : 1;
  localparam int unsigned WW   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_UNLOAD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [JW-1:0]   j_q, j_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [DW-1:0]   frame_q [L];
  logic [DW-1:0]   frame_d [L];
  logic [DW-1:0]   ybuf_q [NX];
  logic [DW-1:0]   ybuf_d [NX];
  logic [DW-1:0]   ybuf_in [NX];
  logic            in_ready_q, in_ready_d;
  logic            start_q, start_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  // The whole frame lives in one word array; each tensor bus is a fixed window of it.
  for (genvar g = 0; g < NBH; g++) begin : g_bh
    assign dt_flat[g*DW +: DW] = frame_q[O_DT + g];
    assign dA_flat[g*DW +: DW] = frame_q[O_DA + g];
  end
  for (genvar g = 0; g < NBN; g++) begin : g_bn
    assign Bmat_flat[g*DW +: DW] = frame_q[O_BM + g];
    assign C_flat[g*DW +: DW]    = frame_q[O_C + g];
  end
  for (genvar g = 0; g < H; g++) begin : g_d
    assign D_flat[g*DW +: DW] = frame_q[O_D + g];
  end
  for (genvar g = 0; g < NX; g++) begin : g_x
    assign x_flat[g*DW +: DW] = frame_q[O_X + g];
    assign ybuf_in[g]         = y_flat_in[g*DW +: DW];
  end
  for (genvar g = 0; g < NHP; g++) begin : g_hp
    assign h_prev_flat[g*DW +: DW] = frame_q[O_HP + g];
  end

  assign in_ready    = in_ready_q;
  assign ssm_start   = start_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      j_q         <= '0;
      wd_q        <= '0;
      frame_q     <= '{default: '0};
      ybuf_q      <= '{default: '0};
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      wd_q        <= wd_d;
      frame_q     <= frame_d;
      ybuf_q      <= ybuf_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next state; handshake outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    j_d     = j_q;
    wd_d    = wd_q;
    err_d   = err_q;
    frame_d = frame_q;
    ybuf_d  = ybuf_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          frame_d[idx_q] = in_data;
          if (idx_q == IW'(L - 1)) begin
            idx_d   = '0;
            state_d = S_FIRE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIRE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ssm_done) begin
          ybuf_d  = ybuf_in;
          j_d     = '0;
          wd_d    = '0;
          state_d = S_UNLOAD;
        end else if (wd_q == WW'(TO_CYC - 1)) begin
          err_d   = 1'b1;
          idx_d   = '0;
          wd_d    = '0;
          state_d = S_LOAD;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (j_q == JW'(NX - 1)) begin
            j_d     = '0;
            state_d = S_LOAD;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    in_ready_d  = (state_d == S_LOAD);
    start_d     = (state_d == S_FIRE);
    busy_d      = (state_d != S_LOAD);
    out_valid_d = (state_d == S_UNLOAD);
    out_last_d  = (state_d == S_UNLOAD) && (j_d == JW'(NX - 1));
    out_data_d  = ybuf_d[j_d];
  end
endmodule

// File: tb/tb_ssm_io_sequencer.sv
// Scoreboard bench for ssm_io_sequencer: random handshakes, frame/tensor model, watchdog and reset cases.
module tb_ssm_io_sequencer;
  localparam int B = 1, H = 4, P = 4, N = 4, DW = 16, TO = 64;
  localparam int BH = B*H, BN = B*N, NX = B*H*P, NHP = B*H*P*N;
  localparam int L = 2*BH + 2*BN + H + NX + NHP;
  localparam int MAXW = NHP*DW;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, ssm_start, ssm_done, out_valid, out_ready, out_last, busy, err_timeout;
  logic [DW-1:0] in_data, out_data;
  logic [BH*DW-1:0] dt_flat, dA_flat;
  logic [BN*DW-1:0] Bmat_flat, C_flat;
  logic [H*DW-1:0] D_flat;
  logic [NX*DW-1:0] x_flat, y_flat_in;
  logic [NHP*DW-1:0] h_prev_flat;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ssm_io_sequencer #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .TO_CYC(TO)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dt_flat(dt_flat), .dA_flat(dA_flat), .Bmat_flat(Bmat_flat), .C_flat(C_flat),
    .D_flat(D_flat), .x_flat(x_flat), .h_prev_flat(h_prev_flat),
    .ssm_start(ssm_start), .ssm_done(ssm_done), .y_flat_in(y_flat_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct { logic [DW-1:0] d; bit last; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] w [L];
  logic [DW-1:0] yw [NX];
  int or_duty = 100;
  int first_valid_cyc = -1, last_xfer_cyc = -1, exp_ready_cyc = -1;
  int start_cnt = 0, exp_starts = 0;
  bit last_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Compare one tensor bus word by word against the frame words at its offset.
  task automatic chk_bus(input string name, input logic [MAXW-1:0] g, input int off, input int nw);
    int bad = -1;
    logic [DW-1:0] gw;
    n_chk++;
    for (int k = 0; k < nw; k++) begin
      gw = g[k*DW +: DW];
      if (bad < 0 && gw !== w[off+k]) bad = k;
    end
    if (bad >= 0) begin
      n_fail++;
      gw = g[bad*DW +: DW];
      $display("FAIL bus_%s word %0d: got %0h, expected %0h", name, bad, gw, w[off+bad]);
    end
  endtask

  task automatic verify_buses();
    int sz[7] = '{BH, BH, BN, BN, H, NX, NHP};
    string nm[7] = '{"dt", "dA", "Bmat", "C", "D", "x", "h_prev"};
    int off = 0;
    logic [MAXW-1:0] g;
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: g = MAXW'(dt_flat);
        1: g = MAXW'(dA_flat);
        2: g = MAXW'(Bmat_flat);
        3: g = MAXW'(C_flat);
        4: g = MAXW'(D_flat);
        5: g = MAXW'(x_flat);
        default: g = h_prev_flat;
      endcase
      chk_bus(nm[t], g, off, sz[t]);
      off += sz[t];
    end
  endtask

  task automatic send(input int first, input int n, input int duty, output int t_last);
    int k = first;
    int guard = 0;
    t_last = -1;
    while (k < first + n && guard < 5000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 99) < duty);
      in_data  = w[k];
      @(negedge clk);
      if (in_valid && in_ready) begin
        t_last = cyc;
        k++;
      end
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("load_count", k, first + n);
  endtask

  task automatic start_chk();
    @(negedge clk);
    chk("start_pulse", ssm_start, 1);
    chk("busy_fire", busy, 1);
    chk("in_ready_fire", in_ready, 0);
    @(negedge clk);
    chk("start_drop", ssm_start, 0);
    chk("in_ready_wait", in_ready, 0);
  endtask

  task automatic run_frame(input int duty, input int lat, input bit y_rand, input bit tchk);
    int t, d;
    exp_t e;
    logic [NX*DW-1:0] y;
    send(0, L, duty, t);
    exp_starts++;
    start_chk();
    verify_buses();
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (lat - 1) @(posedge clk);
    #1;
    d = cyc;
    in_valid = 1'b0;
    for (int j = 0; j < NX; j++) begin
      yw[j] = y_rand ? 16'($urandom) : 16'(16'h3C00 + j);
      y[j*DW +: DW] = yw[j];
      e.d = yw[j];
      e.last = (j == NX - 1);
      sb.push_back(e);
    end
    first_valid_cyc = -1;
    last_seen = 1'b0;
    ssm_done = 1'b1;
    y_flat_in = y;
    @(posedge clk); #1;
    ssm_done = 1'b0;
    y_flat_in = ~y;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (last_seen && sb.size() == 0) break;
    end
    chk("drain", (last_seen && sb.size() == 0) ? 1 : 0, 1);
    chk("first_valid_lat", first_valid_cyc - d, 1);
    if (tchk) chk("last_lat", last_xfer_cyc - d, NX);
    verify_buses();
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 99) < or_duty);
    end
  end

  // Output monitor: pops the scoreboard on every transfer and checks stall stability.
  bit stall_q = 1'b0;
  logic [DW-1:0] prev_d;
  logic prev_l;
  exp_t em;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (ssm_start) start_cnt++;
      if (exp_ready_cyc == cyc) begin
        chk("in_ready_after_last", in_ready, 1);
        chk("valid_after_last", out_valid, 0);
      end
      if (stall_q) begin
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          em = sb.pop_front();
          chk("out_data", out_data, em.d);
          chk("out_last", out_last, em.last);
          if (em.last) begin
            last_xfer_cyc = cyc;
            exp_ready_cyc = cyc + 1;
            last_seen = 1'b1;
          end
        end
      end
      stall_q = out_valid && !out_ready;
      prev_d  = out_data;
      prev_l  = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ssm_done = 1'b0; y_flat_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", ssm_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_dt", 64'(dt_flat), 0);
    chk("rst_hprev_zero", (h_prev_flat == '0) ? 1 : 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp frame, always-ready, done 50 cycles after start
    for (int k = 0; k < L; k++) w[k] = 16'(k);
    run_frame(100, 50, 1'b0, 1'b1);
    chk("dt0", dt_flat[15:0], 0);
    chk("dA0", dA_flat[15:0], 4);
    chk("C0", C_flat[15:0], 12);
    chk("hprev0", h_prev_flat[15:0], 36);

    // Same frame with 30% valid/ready duty
    or_duty = 30;
    run_frame(30, 50, 1'b0, 1'b0);
    // Random data with random handshakes
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    run_frame(30, 20, 1'b1, 1'b0);
    or_duty = 100;

    // Done pulse while loading must be ignored
    @(posedge clk); #1;
    ssm_done = 1'b1; y_flat_in = '1;
    @(posedge clk); #1;
    ssm_done = 1'b0;
    @(negedge clk);
    chk("done_in_load_ready", in_ready, 1);
    chk("done_in_load_busy", busy, 0);
    chk("done_in_load_valid", out_valid, 0);
    @(negedge clk);
    chk("done_in_load_valid2", out_valid, 0);

    // Done on the last watchdog cycle wins over timeout
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    run_frame(100, TO, 1'b1, 1'b1);
    chk("err_done_wins", err_timeout, 0);

    // Watchdog expiry
    send(0, L, 100, t);
    exp_starts++;
    start_chk();
    repeat (TO - 1) @(negedge clk);
    chk("err_before_expiry", err_timeout, 0);
    chk("busy_last_wait", busy, 1);
    @(negedge clk);
    chk("err_set", err_timeout, 1);
    chk("in_ready_after_to", in_ready, 1);
    chk("busy_after_to", busy, 0);
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    run_frame(100, 30, 1'b1, 1'b1);
    chk("err_sticky", err_timeout, 1);

    // Reset after 40 words, then a fresh full frame
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    send(0, 40, 100, t);
    rst = 1'b1;
    #1;
    chk("midload_rst_ready", in_ready, 1);
    chk("midload_rst_err", err_timeout, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    run_frame(100, 50, 1'b1, 1'b1);
    chk("dt0_after_rst", dt_flat[15:0], w[0]);

    // Reset during FIRE drops start at once
    send(0, L, 100, t);
    chk("start_in_fire", ssm_start, 1);
    rst = 1'b1;
    #1;
    chk("start_async_drop", ssm_start, 0);
    chk("fire_rst_ready", in_ready, 1);
    chk("fire_rst_bus", 64'(dt_flat), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("fire_rst_start_low", ssm_start, 0);
    chk("fire_rst_valid", out_valid, 0);
    for (int k = 0; k < L; k++) w[k] = 16'($urandom);
    run_frame(100, 10, 1'b1, 1'b1);

    chk("start_count", start_cnt, exp_starts);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ssm_io_sequencer.md
# ssm_io_sequencer

Host-side initiator for the fp16 SSM block (`ssm_block_fp16_top`). It receives one frame of operands as a stream of DW-bit words over a valid/ready interface and packs them into the flat operand buses. It then issues the single-cycle `start` pulse, waits for `done`, and captures `y_flat`. Finally it streams the result back out word by word over a second valid/ready interface.

## Interface
Parameters:
- B, 1, batch
- H, 4, heads
- P, 4, head dim
- N, 4, state dim
- DW, 16, fp16 word width
- TO_CYC, 4096, watchdog limit in cycles while waiting for `ssm_done`

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  high only in LOAD
- in_data  in  DW  operand word
- dt_flat, dA_flat  out  B*H*DW  packed operands
- Bmat_flat, C_flat  out  B*N*DW  packed operands
- D_flat  out  H*DW  packed operand
- x_flat  out  B*H*P*DW  packed operand
- h_prev_flat  out  B*H*P*N*DW  packed operand
- ssm_start  out  1  one-cycle start pulse to the SSM block
- ssm_done  in  1  one-cycle done pulse from the SSM block
- y_flat_in  in  B*H*P*DW  SSM result; valid in the `ssm_done` cycle
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts the result word
- out_data  out  DW  result word
- out_last  out  1  marks the final result word of the frame
- busy  out  1  high in FIRE, WAIT or UNLOAD
- err_timeout  out  1  sticky watchdog flag; cleared only by rst

## Operation
- Frame load order: dt (B*H words), dA (B*H), Bmat (B*N), C (B*N), D (H), x (B*H*P), h_prev (B*H*P*N).
- Frame length L = 2BH + 2BN + H + BHP + BHPN. With the default parameters, L = 100.
- Word k of each tensor is written to bits [k*DW +: DW] of that tensor's flat bus.
- Internal counters: a load index (0..L-1) with region decode, an unload index (0..BHP-1), and a watchdog counter of width clog2(TO_CYC).
- State machine:
  - LOAD (reset state): accept a word when in_valid && in_ready and increment the index. When the word with index L-1 is accepted, go to FIRE.
  - FIRE: hold ssm_start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: when ssm_done = 1, register y_flat_in into y_buf and go to UNLOAD. Otherwise increment the watchdog. If the watchdog reaches TO_CYC-1, set err_timeout, clear the load index and go to LOAD; the frame is dropped.
  - UNLOAD: out_data = y_buf word j and out_valid = 1. Advance j on out_valid && out_ready. out_last = (j == BHP-1). After the last word is transferred, clear the counters and go to LOAD.
- The operand buses are registers and change only on accepted LOAD words. They are therefore stable from FIRE through WAIT, which the SSM block requires.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values:
  - state = LOAD; in_ready = 1
  - all operand buses = 0; y_buf = 0
  - ssm_start, out_valid, out_last, busy, err_timeout = 0
  - all counters = 0
- An in_valid gap stalls loading and does not reset the index. An out_ready stall holds out_data and out_last stable.
- The last input acceptance is at cycle t. Then ssm_start is high at t+1 and WAIT begins at t+2.
- ssm_done at cycle d gives out_valid = 1 at d+1. With out_ready held high, out_last is at d+BHP and LOAD with in_ready = 1 is at d+BHP+1.
- If ssm_done arrives in the same cycle the watchdog would expire, done wins and err_timeout is not set.
- ssm_done outside WAIT is ignored.
- in_ready = 0 outside LOAD; input words offered then are not consumed.
- If rst is asserted mid-frame in any state, the block returns to LOAD immediately. The partial frame and any pending result are discarded. ssm_start drops asynchronously.
- Back-to-back frames: the next frame may begin loading in the cycle after the final out_last transfer.

## Test plan
- Load 100 words with in_data = k (default parameters), ready always high. Check dt_flat[15:0] = 0, dA_flat[15:0] = 4, C_flat[15:0] = 12, h_prev_flat[15:0] = 36. Check exactly one ssm_start pulse, in the cycle after word 99.
- Model ssm_done 50 cycles after start with y_flat_in word j = 16'h3C00 + j. Check out_data sequence 3C00..3C0F, out_last only on the 16th word, and in_ready = 1 in the following cycle.
- Apply random in_valid and out_ready duty of 30%. Check no dropped or duplicated words and the same packed buses and output sequence as in the first two scenarios.
- Set TO_CYC = 16 and never assert done. Check err_timeout = 1 at the 16th WAIT cycle, return to LOAD, and the flag still set after a subsequent good frame.
- Assert rst after 40 words are loaded, then send a full frame. Check that the first new word lands in dt_flat[15:0] and that start fires only after 100 new words.
- Pulse ssm_done during LOAD. Check there is no state change and out_valid stays 0.
